// File: rtl/hazard_sequencer.sv
// Stall/flush/forward sequencer for the five-stage F/D/E/M/W pipeline.
// Optional feature: define HAZARD_FORWARDING_EN to enable E-stage forwarding.
module hazard_sequencer #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rs1E,
    input  logic [REG_ADDR_W-1:0] rs2E,
    input  logic [REG_ADDR_W-1:0] rdE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteE,
    input  logic                  regWriteM,
    input  logic                  regWriteW,
    input  logic                  loadE,
    input  logic                  redirectE,
    input  logic                  memReqM,
    input  logic                  memReadyM,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushW,
    output logic [1:0]            rs1ForwardE,
    output logic [1:0]            rs2ForwardE,
    output logic [PERF_W-1:0]     stallCount,
    output logic [PERF_W-1:0]     flushCount
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [1:0] NO_FORWARD = 2'd0;
    localparam logic [1:0] COMPUTE    = 2'd1;
    localparam logic [1:0] MEMORY     = 2'd2;

    localparam logic [REG_ADDR_W-1:0] X0  = '0;
    localparam logic [PERF_W-1:0]     ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [0:0] state;
    logic [0:0] state_next;
    logic       freeze;
    logic       data_stall;
    logic [1:0] fwd1;
    logic [1:0] fwd2;

    always_comb begin
        freeze = 1'b0;
        case (state)
            IDLE:     freeze = memReqM & ~memReadyM;
            MEM_WAIT: freeze = ~memReadyM;
            default:  freeze = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (memReqM && !memReadyM) state_next = MEM_WAIT;
            MEM_WAIT: if (memReadyM)             state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results; only a load in E must wait a cycle.
    logic unused_fwd_cfg;
    assign unused_fwd_cfg = regWriteE;

    always_comb begin
        data_stall = loadE && (rdE != X0) &&
                     ((rdE == rs1D) || (rdE == rs2D));
    end

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        sel = NO_FORWARD;
        if (rs != X0) begin
            if (we_m && (rd_m == rs))      sel = COMPUTE;
            else if (we_w && (rd_w == rs)) sel = MEMORY;
        end
        return sel;
    endfunction

    always_comb begin
        fwd1 = fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW);
        fwd2 = fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW);
    end
`else
    // No bypass: D waits until producers in E or M have reached W.
    logic unused_fwd_cfg;
    assign unused_fwd_cfg = ^{rs1E, rs2E, rdW, regWriteW, loadE};

    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = (rs1D != X0) &&
               ((regWriteE && (rdE == rs1D)) ||
                (regWriteM && (rdM == rs1D)));
        hit2 = (rs2D != X0) &&
               ((regWriteE && (rdE == rs2D)) ||
                (regWriteM && (rdM == rs2D)));
        data_stall = hit1 || hit2;
    end

    always_comb begin
        fwd1 = NO_FORWARD;
        fwd2 = NO_FORWARD;
    end
`endif

    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        rs1ForwardE = reset ? NO_FORWARD : fwd1;
        rs2ForwardE = reset ? NO_FORWARD : fwd2;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else if (freeze) begin
            // Hold F..M; W retires a bubble so nothing writes twice.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (redirectE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (data_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallF && (stallCount != '1))
                stallCount <= stallCount + ONE;
            if (flushD && (flushCount != '1))
                flushCount <= flushCount + ONE;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed + random bench for hazard_sequencer against a rule-level model.
// Follows HAZARD_FORWARDING_EN the same way the design does.
module tb_hazard_sequencer;

    localparam int RW = 5;
    localparam int PW = 4;
    localparam int CMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          regWriteE, regWriteM, regWriteW;
    logic          loadE, redirectE, memReqM, memReadyM;
    logic          stallF, stallD, stallE, stallM;
    logic          flushD, flushE, flushW;
    logic [1:0]    rs1ForwardE, rs2ForwardE;
    logic [PW-1:0] stallCount, flushCount;

    int checks = 0;
    int errors = 0;

    bit m_pending = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        bit sf, sd, se, sm;
        bit fd, fe, fw;
        bit [1:0] f1, f2;
    } exp_t;

    hazard_sequencer #(.REG_ADDR_W(RW), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rdM(rdM), .rdW(rdW),
        .regWriteE(regWriteE), .regWriteM(regWriteM),
        .regWriteW(regWriteW), .loadE(loadE),
        .redirectE(redirectE), .memReqM(memReqM),
        .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .rs1ForwardE(rs1ForwardE), .rs2ForwardE(rs2ForwardE),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    function automatic bit hits(input logic [RW-1:0] rd,
                                input logic [RW-1:0] rs);
        return (rd != 0) && (rd == rs);
    endfunction

    function automatic bit [1:0] fwd_of(input logic [RW-1:0] rs);
`ifdef HAZARD_FORWARDING_EN
        if (regWriteM && hits(rdM, rs)) return 2'd1;
        if (regWriteW && hits(rdW, rs)) return 2'd2;
`endif
        return 2'd0;
    endfunction

    function automatic bit frozen_now();
        return !memReadyM && (m_pending || memReqM);
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit dstall;
        e = '{default: 0};
`ifdef HAZARD_FORWARDING_EN
        dstall = loadE && (hits(rdE, rs1D) || hits(rdE, rs2D));
`else
        dstall = (regWriteE && (hits(rdE, rs1D) || hits(rdE, rs2D)))
              || (regWriteM && (hits(rdM, rs1D) || hits(rdM, rs2D)));
`endif
        if (reset) begin
            e.fd = 1; e.fe = 1; e.fw = 1;
            return e;
        end
        e.f1 = fwd_of(rs1E);
        e.f2 = fwd_of(rs2E);
        if (frozen_now()) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else if (redirectE) begin
            e.fd = 1; e.fe = 1;
        end else if (dstall) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        bit fz;
        @(negedge clk);
        e = model();
        fz = frozen_now();
        chk("stallF", 32'(stallF), 32'(e.sf));
        chk("stallD", 32'(stallD), 32'(e.sd));
        chk("stallE", 32'(stallE), 32'(e.se));
        chk("stallM", 32'(stallM), 32'(e.sm));
        chk("flushD", 32'(flushD), 32'(e.fd));
        chk("flushE", 32'(flushE), 32'(e.fe));
        chk("flushW", 32'(flushW), 32'(e.fw));
        chk("rs1Fwd", 32'(rs1ForwardE), 32'(e.f1));
        chk("rs2Fwd", 32'(rs2ForwardE), 32'(e.f2));
        chk("stallCount", 32'(stallCount), 32'(m_stall));
        chk("flushCount", 32'(flushCount), 32'(m_flush));
        if (reset) begin
            m_pending = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_pending = fz;
            if (e.sf && m_stall < CMAX) m_stall++;
            if (e.fd && m_flush < CMAX) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0;
        loadE = 0; redirectE = 0; memReqM = 0; memReadyM = 0;
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        step();

        // Forward priority M over W, then x0 never forwards
        regWriteM = 1; rdM = 5; rs1E = 5;
        regWriteW = 1; rdW = 5; rs2E = 5;
        step();
        rdM = 0; rs1E = 0;
        step();
        idle_inputs();

        // Load-use bubble, then same hazard under redirect
        loadE = 1; regWriteE = 1; rdE = 7; rs2D = 7;
        step();
        loadE = 0; regWriteE = 0; rs2D = 0;
        step();
        loadE = 1; regWriteE = 1; rs2D = 7; redirectE = 1;
        step();
        idle_inputs();

        // Three wait cycles then ready
        memReqM = 1; memReadyM = 0;
        step(); step(); step();
        memReadyM = 1;
        step();
        memReqM = 0; memReadyM = 0;
        step();

        // Redirect held across a two-cycle freeze
        redirectE = 1; memReqM = 1; memReadyM = 0;
        step(); step();
        memReadyM = 1;
        step();
        idle_inputs();
        step();

        // Zero-wait access
        memReqM = 1; memReadyM = 1;
        step(); step();
        idle_inputs();

        // Bring stallCount to 10, park in MEM_WAIT, then reset
        guard = 0;
        loadE = 1; regWriteE = 1; rdE = 7; rs1D = 7;
        while (m_stall < 10 && guard < 40) begin
            step();
            guard++;
        end
        idle_inputs();
        memReqM = 1; memReadyM = 0;
        step(); step();
        reset = 1;
        step();
        reset = 0;
        memReqM = 0;
        @(negedge clk);
        chk("rst_stallCount", 32'(stallCount), 32'd0);
        chk("rst_flushCount", 32'(flushCount), 32'd0);
        chk("rst_stallF", 32'(stallF), 32'd0);
        @(posedge clk);
        #1;
        step();

        // M-stage producer read in D
        regWriteM = 1; rdM = 3; rs1D = 3;
        step();
        idle_inputs();

        // Saturate both counters
        memReqM = 1; memReadyM = 0;
        for (int i = 0; i < 20; i++) step();
        memReadyM = 1; memReqM = 0;
        step();
        idle_inputs();
        redirectE = 1;
        for (int i = 0; i < 20; i++) step();
        idle_inputs();

        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            rs1D      = RW'($urandom_range(0, 3));
            rs2D      = RW'($urandom_range(0, 3));
            rs1E      = RW'($urandom_range(0, 3));
            rs2E      = RW'($urandom_range(0, 3));
            rdE       = RW'($urandom_range(0, 3));
            rdM       = RW'($urandom_range(0, 3));
            rdW       = RW'($urandom_range(0, 3));
            regWriteE = 1'($urandom);
            regWriteM = 1'($urandom);
            regWriteW = 1'($urandom);
            loadE     = ($urandom_range(0, 3) == 0);
            redirectE = ($urandom_range(0, 4) == 0);
            memReqM   = ($urandom_range(0, 2) == 0);
            memReadyM = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
